// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a word-addressed on-chip RAM (scratchpad / data-side memory model).
// Latency: request accepted at edge T, data_ok high for one cycle in cycle T+LATENCY (LATENCY 1..15).
// Backpressure: addr_ok only in IDLE, so at most one request in flight; min issue interval LATENCY+1.
// Ports: clk, reset (async active-high), dreq (dbus_req_t in), dresp (dbus_resp_t out), busy (out),
//        misalign (out, only when DBUS_RESP_MISALIGN_CHECK_EN is defined: flags a misaligned
//        request in its RESP cycle and suppresses that request's write).
package dbus_pkg;
  typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2} msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
  ,
  output logic       misalign
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t               state, stateNext;
  logic [3:0]           cnt, cntNext;
  logic [ADDR_BITS-1:0] reqIdx;
  logic [3:0]           reqStrobe;
  logic [31:0]          reqData;
  logic                 accept;
  logic                 writeEn;
  logic                 misalignNow;

  logic [31:0] mem [2**ADDR_BITS];

  // Gated by reset so addr_ok reads 0 while reset is held, even with valid high.
  assign accept = (state == IDLE) && dreq.valid && !reset;

`ifdef DBUS_RESP_MISALIGN_CHECK_EN
  logic [1:0] reqLow;
  msize_t     reqSize;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqLow  <= 2'b00;
      reqSize <= MSIZE1;
    end else if (accept) begin
      reqLow  <= dreq.addr[1:0];
      reqSize <= dreq.size;
    end
  end

  always_comb begin
    misalignNow = 1'b0;
    if (reqSize == MSIZE2) misalignNow = reqLow[0];
    else if (reqSize == MSIZE4) misalignNow = (reqLow != 2'b00);
  end

  logic unusedAddrBits;
  assign unusedAddrBits = ^dreq.addr[31:ADDR_BITS+2];
`else
  assign misalignNow = 1'b0;

  // Size and byte offset only matter for the alignment check.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{dreq.addr[31:ADDR_BITS+2], dreq.addr[1:0], dreq.size};
`endif

  // State register plus the request latch and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      reqIdx    <= '0;
      reqStrobe <= 4'd0;
      reqData   <= 32'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        reqIdx    <= dreq.addr[ADDR_BITS+1:2];
        reqStrobe <= dreq.strobe;
        reqData   <= dreq.data;
      end
    end
  end

  // Next-state logic. The counter holds the WAIT cycles still to go, so
  // leaving WAIT on cnt==1 puts RESP exactly LATENCY cycles after accept.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cntNext   = 4'(LATENCY - 1);
          stateNext = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cntNext = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cntNext   = 4'd0;
          stateNext = RESP;
        end
      end
      RESP: begin
        cntNext   = 4'd0;
        stateNext = IDLE;
      end
      default: begin
        cntNext   = 4'd0;
        stateNext = IDLE;
      end
    endcase
  end

  // Outputs. RAM read is combinational, so RESP returns the word as it was
  // before the write that commits on the closing edge.
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = accept;
    busy          = (state != IDLE);
    writeEn       = 1'b0;
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
    misalign      = 1'b0;
`endif
    if (state == RESP) begin
      dresp.data_ok = 1'b1;
      dresp.data    = mem[reqIdx];
      writeEn       = (reqStrobe != 4'd0) && !misalignNow;
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
      misalign      = misalignNow;
`endif
    end
  end

  // RAM contents are deliberately not reset; an async reset drops state to
  // IDLE first, so an uncommitted write never lands.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      for (int i = 0; i < 4; i++) begin
        if (reqStrobe[i]) mem[reqIdx][i*8 +: 8] <= reqData[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder at ADDR_BITS=10, LATENCY=2.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Covers reset, store/load, byte lanes, hold-valid throttling, wrap, mid-op reset, misalign.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int LAT = 2;

  logic       clk;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       busy;
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
  logic       misalign;
  logic       lastMis;
`endif

  int assertCnt = 0;
  int failCnt   = 0;

  dbus_sram_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .dreq    (dreq),
    .dresp   (dresp),
    .busy    (busy)
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
    ,
    .misalign(misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, wait for data_ok (bounded), return the
  // response data and the number of edges from accept to data_ok.
  task automatic doReq(input logic [31:0] a, input msize_t sz, input logic [3:0] st,
                       input logic [31:0] d, output logic [31:0] rd, output int lat,
                       output logic aok);
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = sz;
    dreq.strobe = st;
    dreq.data   = d;
    #1;
    aok = dresp.addr_ok;
    tick();
    dreq.valid = 1'b0;
    #1;
    lat = 1;
    while (!dresp.data_ok && lat < 20) begin
      tick();
      lat++;
    end
    rd = dresp.data;
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
    lastMis = misalign;
`endif
    tick();
  endtask

  logic [31:0] rd;
  int          lat;
  logic        aok;
  int          okCount;

  initial begin
    dreq  = '0;
    reset = 1'b1;
    #1;
    checkVal("rst_addr_ok_idle", {31'd0, dresp.addr_ok}, 32'd0);
    dreq.valid = 1'b1;
    #1;
    checkVal("rst_addr_ok_valid", {31'd0, dresp.addr_ok}, 32'd0);
    checkVal("rst_data_ok", {31'd0, dresp.data_ok}, 32'd0);
    checkVal("rst_data", dresp.data, 32'd0);
    checkVal("rst_busy", {31'd0, busy}, 32'd0);
    dreq.valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Full-word store then load.
    doReq(32'h10, MSIZE4, 4'hF, 32'hDEADBEEF, rd, lat, aok);
    checkVal("st_addr_ok", {31'd0, aok}, 32'd1);
    checkVal("st_latency", lat, LAT);
    checkVal("after_resp_data_ok", {31'd0, dresp.data_ok}, 32'd0);
    checkVal("after_resp_data", dresp.data, 32'd0);
    doReq(32'h10, MSIZE4, 4'h0, 32'h0, rd, lat, aok);
    checkVal("ld_latency", lat, LAT);
    checkVal("ld_data", rd, 32'hDEADBEEF);

    // Byte store into lane 3; store returns the old word.
    doReq(32'h13, MSIZE1, 4'b1000, 32'h5A000000, rd, lat, aok);
    checkVal("bst_old_word", rd, 32'hDEADBEEF);
    doReq(32'h10, MSIZE4, 4'h0, 32'h0, rd, lat, aok);
    checkVal("bst_merged", rd, 32'h5AADBEEF);

    // Hold valid high through WAIT/RESP: exactly one accept per LAT+1 cycles.
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h10;
    dreq.size   = MSIZE4;
    dreq.strobe = 4'h0;
    dreq.data   = 32'h0;
    #1;
    checkVal("hold_c0_addr_ok", {31'd0, dresp.addr_ok}, 32'd1);
    okCount = 0;
    tick();
    checkVal("hold_c1_addr_ok", {31'd0, dresp.addr_ok}, 32'd0);
    checkVal("hold_c1_busy", {31'd0, busy}, 32'd1);
    if (dresp.data_ok) okCount++;
    tick();
    checkVal("hold_c2_addr_ok", {31'd0, dresp.addr_ok}, 32'd0);
    checkVal("hold_c2_data", dresp.data, 32'h5AADBEEF);
    if (dresp.data_ok) okCount++;
    tick();
    checkVal("hold_c3_addr_ok", {31'd0, dresp.addr_ok}, 32'd1);
    if (dresp.data_ok) okCount++;
    checkVal("hold_one_data_ok", okCount, 1);
    dreq.valid = 1'b0;
    tick();
    tick();
    tick();
    checkVal("hold_idle_busy", {31'd0, busy}, 32'd0);

    // Address wrap above the RAM range; low two address bits ignored.
    doReq(32'h1000, MSIZE4, 4'hF, 32'h11223344, rd, lat, aok);
    doReq(32'h0, MSIZE4, 4'h0, 32'h0, rd, lat, aok);
    checkVal("wrap_ld", rd, 32'h11223344);
    doReq(32'h3, MSIZE1, 4'h0, 32'h0, rd, lat, aok);
    checkVal("wrap_ld_lowbits", rd, 32'h11223344);

    // Reset in WAIT of a store: dropped, no data_ok, write discarded.
    doReq(32'h20, MSIZE4, 4'hF, 32'h0, rd, lat, aok);
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h20;
    dreq.size   = MSIZE4;
    dreq.strobe = 4'hF;
    dreq.data   = 32'hCAFEF00D;
    tick();
    dreq.valid = 1'b0;
    checkVal("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkVal("mid_busy", {31'd0, busy}, 32'd0);
    checkVal("mid_data_ok", {31'd0, dresp.data_ok}, 32'd0);
    checkVal("mid_data", dresp.data, 32'd0);
    tick();
    reset = 1'b0;
    okCount = 0;
    for (int i = 0; i < 4; i++) begin
      if (dresp.data_ok) okCount++;
      tick();
    end
    checkVal("mid_no_data_ok", okCount, 0);
    doReq(32'h20, MSIZE4, 4'h0, 32'h0, rd, lat, aok);
    checkVal("mid_write_dropped", rd, 32'h0);

`ifdef DBUS_RESP_MISALIGN_CHECK_EN
    doReq(32'h22, MSIZE4, 4'hF, 32'h12345678, rd, lat, aok);
    checkVal("mis_w4_flag", {31'd0, lastMis}, 32'd1);
    checkVal("mis_idle_flag", {31'd0, misalign}, 32'd0);
    doReq(32'h22, MSIZE2, 4'h0, 32'h0, rd, lat, aok);
    checkVal("mis_h2_flag", {31'd0, lastMis}, 32'd0);
    checkVal("mis_word_kept", rd, 32'h0);
    doReq(32'h21, MSIZE2, 4'h0, 32'h0, rd, lat, aok);
    checkVal("mis_h1_flag", {31'd0, lastMis}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
